// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: FFT output stream into the peak detector, plus its per-frame result.
interface fft_peak_detect_if #(
  parameter int REAL_WIDTH  = 18,
  parameter int IMGN_WIDTH  = 18,
  parameter int TOTAL_STAGE = 8
);
  localparam int POW_WIDTH = 2 * (REAL_WIDTH > IMGN_WIDTH ? REAL_WIDTH : IMGN_WIDTH) + 1;
  logic signed [REAL_WIDTH-1:0] iReal;
  logic signed [IMGN_WIDTH-1:0] iImag;
  logic [TOTAL_STAGE-1:0]       iaddr;
  logic                         ien;
  logic [TOTAL_STAGE-1:0]       opeak_addr;
  logic [POW_WIDTH-1:0]         opeak_pow;
  logic                         ovalid;
  logic                         oerr;
  modport master (output iReal, iImag, iaddr, ien, input opeak_addr, opeak_pow, ovalid, oerr);
  modport slave  (input iReal, iImag, iaddr, ien, output opeak_addr, opeak_pow, ovalid, oerr);
endinterface

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame max |X|^2 bin search over the natural-order FFT output stream.
module fft_peak_detect #(
  parameter int REAL_WIDTH  = 18,
  parameter int IMGN_WIDTH  = 18,
  parameter int TOTAL_STAGE = 8,
  parameter int SEARCH_HALF = 1
) (
  input logic              iclk,
  input logic              rst_n,
  fft_peak_detect_if.slave bus
);
  localparam int W         = REAL_WIDTH > IMGN_WIDTH ? REAL_WIDTH : IMGN_WIDTH;
  localparam int POW_WIDTH = 2 * W + 1;
  localparam logic [TOTAL_STAGE-1:0] LAST = '1;
  typedef enum logic {IDLE, ACC} state_t;
  state_t                           state_q;
  logic [TOTAL_STAGE-1:0]           exp_q;
  logic [1:0]                       fid_q;
  logic                             oerr_q;
  logic signed [REAL_WIDTH-1:0]     re1_q;
  logic signed [IMGN_WIDTH-1:0]     im1_q;
  logic [2*REAL_WIDTH-1:0]          sre2_q;
  logic [2*IMGN_WIDTH-1:0]          sim2_q;
  logic [POW_WIDTH-1:0]             pow3_q, max_q, peak_pow_q;
  logic [TOTAL_STAGE-1:0]           a1_q, a2_q, a3_q, max_addr_q, peak_addr_q;
  logic [3:1]                       v_q, st_q, ls_q, live_d;
  logic [3:1][1:0]                  id_q;
  logic                             done_q, ovalid_q;
  logic                             hit_d, abort_d, start_d, acc_d, last_d, srch_d;
  logic signed [2*REAL_WIDTH-1:0]   re_x_d;
  logic signed [2*IMGN_WIDTH-1:0]   im_x_d;
  assign hit_d   = bus.ien && state_q == ACC && bus.iaddr == exp_q;
  assign abort_d = bus.ien && state_q == ACC && bus.iaddr != exp_q;
  assign start_d = bus.ien && bus.iaddr == '0 && (state_q == IDLE || abort_d);
  assign acc_d   = hit_d || start_d;
  assign last_d  = hit_d && bus.iaddr == LAST;
  assign srch_d  = !(SEARCH_HALF != 0 && a3_q[TOTAL_STAGE-1]);
  assign re_x_d  = (2*REAL_WIDTH)'(re1_q);
  assign im_x_d  = (2*IMGN_WIDTH)'(im1_q);
  // An abort kills only in-flight samples tagged with the aborted frame's id,
  // so an older completed frame still reaches its ovalid.
  always_comb begin
    live_d = v_q;
    for (int k = 1; k <= 3; k++)
      live_d[k] = v_q[k] && !(abort_d && id_q[k] == fid_q);
  end
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      fid_q   <= '0;
      oerr_q  <= 1'b0;
    end else begin
      oerr_q <= abort_d;
      if (start_d) begin
        state_q <= ACC;
        exp_q   <= TOTAL_STAGE'(1);
        fid_q   <= fid_q + 2'd1;
      end else if (abort_d || last_d) state_q <= IDLE;
      else if (hit_d) exp_q <= exp_q + TOTAL_STAGE'(1);
    end
  end
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      {v_q, st_q, ls_q, id_q} <= '0;
      {re1_q, im1_q, a1_q, sre2_q, sim2_q, a2_q, pow3_q, a3_q} <= '0;
      {max_q, max_addr_q, done_q, ovalid_q, peak_pow_q, peak_addr_q} <= '0;
    end else begin
      v_q   <= {live_d[2], live_d[1], acc_d};
      st_q  <= {st_q[2:1], start_d};
      ls_q  <= {ls_q[2:1], last_d};
      id_q  <= {id_q[2:1], start_d ? fid_q + 2'd1 : fid_q};
      re1_q <= bus.iReal;
      im1_q <= bus.iImag;
      a1_q  <= bus.iaddr;
      sre2_q <= re_x_d * re_x_d;
      sim2_q <= im_x_d * im_x_d;
      a2_q  <= a1_q;
      pow3_q <= POW_WIDTH'(sre2_q) + POW_WIDTH'(sim2_q);
      a3_q  <= a2_q;
      if (live_d[3] && srch_d && (st_q[3] || pow3_q > max_q)) begin
        max_q      <= pow3_q;
        max_addr_q <= a3_q;
      end
      done_q   <= live_d[3] && ls_q[3];
      ovalid_q <= done_q;
      if (done_q) begin
        peak_pow_q  <= max_q;
        peak_addr_q <= max_addr_q;
      end
    end
  end
  assign bus.opeak_addr = peak_addr_q;
  assign bus.opeak_pow  = peak_pow_q;
  assign bus.ovalid     = ovalid_q;
  assign bus.oerr       = oerr_q;
endmodule
